// File: rtl/ad9648_spi_master.sv
// AD9648 3-wire SPI initiator with optional readback (AD9648_SPI_READBACK_EN).
// Done arrives 1+CsSetup+48*ClkDiv+CsHold cycles after accept; starts while busy are dropped.
module ad9648_spi_master #(
   parameter int TxRegWidth = 24,
   parameter int RxRegWidth = 8,
   parameter int ClkDiv     = 4,
   parameter int CsSetup    = 2,
   parameter int CsHold     = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_clk_n_i,
   input  logic [TxRegWidth-1:0] tx_reg_i,
   input  logic                  transfer_start_i,
   output logic [RxRegWidth-1:0] rx_reg_o,
   output logic                  transfer_done_o,
   output logic                  busy_o,
   output logic                  spi_csb_o,
   output logic                  spi_sclk_o,
   output logic                  spi_sdio_o,
   output logic                  spi_sdio_t_o,
   input  logic                  spi_sdio_i
);

`ifdef AD9648_SPI_READBACK_EN
   localparam bit ReadEn = 1'b1;
`else
   localparam bit ReadEn = 1'b0;
`endif

   localparam int CntMax = (ClkDiv > CsSetup) ? ((ClkDiv > CsHold) ? ClkDiv : CsHold)
                                              : ((CsSetup > CsHold) ? CsSetup : CsHold);
   localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam int BitW   = $clog2(TxRegWidth);

   localparam logic [CntW-1:0] DivLast   = CntW'(ClkDiv - 1);
   localparam logic [CntW-1:0] SetupLast = CntW'(CsSetup - 1);
   localparam logic [CntW-1:0] HoldLast  = CntW'(CsHold - 1);
   localparam logic [BitW-1:0] LastBit   = BitW'(TxRegWidth - 1);
   localparam logic [BitW-1:0] TurnBit   = BitW'(TxRegWidth - RxRegWidth);
   localparam logic [BitW-1:0] TurnPrev  = BitW'(TxRegWidth - RxRegWidth - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t                  state;
   logic [CntW-1:0]         cnt;
   logic [BitW-1:0]         bit_cnt;
   logic [TxRegWidth-2:0]   shreg;     // bits still to send after the one on the pin
   logic [RxRegWidth-1:0]   rx_shift;
   logic                    rd;

   always_ff @(posedge clk_i) begin
      if (!rst_clk_n_i) begin
         state           <= IDLE;
         cnt             <= '0;
         bit_cnt         <= '0;
         shreg           <= '0;
         rx_shift        <= '0;
         rd              <= 1'b0;
         rx_reg_o        <= '0;
         transfer_done_o <= 1'b0;
         busy_o          <= 1'b0;
         spi_csb_o       <= 1'b1;
         spi_sclk_o      <= 1'b0;
         spi_sdio_o      <= 1'b0;
         spi_sdio_t_o    <= 1'b1;
      end else begin
         transfer_done_o <= 1'b0;
         case (state)
            IDLE: begin
               // busy still high here means this is the done cycle: hold off one more cycle
               if (busy_o) begin
                  busy_o <= 1'b0;
               end else if (transfer_start_i) begin
                  shreg        <= tx_reg_i[TxRegWidth-2:0];
                  rd           <= ReadEn && tx_reg_i[TxRegWidth-1];
                  rx_shift     <= '0;
                  cnt          <= '0;
                  busy_o       <= 1'b1;
                  spi_csb_o    <= 1'b0;
                  spi_sdio_o   <= tx_reg_i[TxRegWidth-1];
                  spi_sdio_t_o <= 1'b0;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == SetupLast) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (!spi_sclk_o) begin
                  if (cnt == DivLast) begin
                     cnt        <= '0;
                     spi_sclk_o <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  if (cnt == '0 && rd && bit_cnt >= TurnBit)
                     rx_shift <= {rx_shift[RxRegWidth-2:0], spi_sdio_i};
                  if (cnt == DivLast) begin
                     cnt        <= '0;
                     spi_sclk_o <= 1'b0;
                     if (bit_cnt == LastBit) begin
                        state <= HOLD;
                     end else begin
                        bit_cnt    <= bit_cnt + 1'b1;
                        shreg      <= shreg << 1;
                        spi_sdio_o <= shreg[TxRegWidth-2];
                        if (rd && bit_cnt == TurnPrev)
                           spi_sdio_t_o <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (cnt == HoldLast) begin
                  cnt             <= '0;
                  spi_csb_o       <= 1'b1;
                  spi_sdio_t_o    <= 1'b1;
                  transfer_done_o <= 1'b1;
                  if (rd)
                     rx_reg_o <= rx_shift;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ad9648_spi_master.sv
// Bench for ad9648_spi_master: default-timing instance plus a minimum-divider instance,
// both checked every cycle against a transfer-position model and by literal expectations.
module tb_ad9648_spi_master;
   localparam int S0 = 2, C0 = 4, H0 = 2;
   localparam int S1 = 1, C1 = 1, H1 = 1;
`ifdef AD9648_SPI_READBACK_EN
   localparam bit RD_EN = 1'b1;
`else
   localparam bit RD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [1:0][23:0] tx;
   logic [1:0][7:0]  rx;
   logic [1:0]       start, done, busy, csb, sclk, sdo, sdt;
   logic [1:0]       sdio_in = 2'b00;

   ad9648_spi_master #(.ClkDiv(C0), .CsSetup(S0), .CsHold(H0)) dut0 (
      .clk_i(clk), .rst_clk_n_i(rst_n), .tx_reg_i(tx[0]), .transfer_start_i(start[0]),
      .rx_reg_o(rx[0]), .transfer_done_o(done[0]), .busy_o(busy[0]), .spi_csb_o(csb[0]),
      .spi_sclk_o(sclk[0]), .spi_sdio_o(sdo[0]), .spi_sdio_t_o(sdt[0]), .spi_sdio_i(sdio_in[0]));

   ad9648_spi_master #(.ClkDiv(C1), .CsSetup(S1), .CsHold(H1)) dut1 (
      .clk_i(clk), .rst_clk_n_i(rst_n), .tx_reg_i(tx[1]), .transfer_start_i(start[1]),
      .rx_reg_o(rx[1]), .transfer_done_o(done[1]), .busy_o(busy[1]), .spi_csb_o(csb[1]),
      .spi_sclk_o(sclk[1]), .spi_sdio_o(sdo[1]), .spi_sdio_t_o(sdt[1]), .spi_sdio_i(sdio_in[1]));

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic int p_s(input int i); return (i == 0) ? S0 : S1; endfunction
   function automatic int p_c(input int i); return (i == 0) ? C0 : C1; endfunction
   function automatic int p_h(input int i); return (i == 0) ? H0 : H1; endfunction

   logic [7:0] sbyte [2];
   initial begin
      sbyte[0] = 8'h88;
      sbyte[1] = 8'h5A;
   end

   // Transfer-position model: act/t give the offset from the accept cycle.
   bit          act [2] = '{1'b0, 1'b0};
   int          t   [2] = '{0, 0};
   logic [23:0] mw  [2];
   bit          mrd [2] = '{1'b0, 1'b0};
   logic [7:0]  mrx [2] = '{8'h00, 8'h00};

   task automatic model_check(input int i);
      int s, c, h, d, u, bitn;
      bit ec, es, et, shifting, holding;
      s = p_s(i); c = p_c(i); h = p_h(i);
      d = 1 + s + 48 * c + h;
      u = t[i] - 1 - s;
      shifting = act[i] && u >= 0 && u < 48 * c;
      holding  = act[i] && u >= 48 * c && t[i] < d;
      bitn = shifting ? u / (2 * c) : 0;
      ec = !(act[i] && t[i] < d);
      es = shifting && ((u % (2 * c)) >= c);
      et = ec || (mrd[i] && ((shifting && bitn >= 16) || holding));
      chk($sformatf("csb%0d", i),  32'(csb[i]),  32'(ec));
      chk($sformatf("sclk%0d", i), 32'(sclk[i]), 32'(es));
      chk($sformatf("sdt%0d", i),  32'(sdt[i]),  32'(et));
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(act[i]));
      chk($sformatf("done%0d", i), 32'(done[i]), 32'(act[i] && t[i] == d));
      chk($sformatf("rx%0d", i),   32'(rx[i]),   32'(mrx[i]));
      if (!et && !holding)
         chk($sformatf("sdio%0d_bit%0d", i, bitn), 32'(sdo[i]), 32'(mw[i][23 - bitn]));
   endtask

   task automatic model_step(input int i);
      int d;
      d = 1 + p_s(i) + 48 * p_c(i) + p_h(i);
      if (!rst_n) begin
         act[i] = 1'b0;
         mrx[i] = 8'h00;
      end else if (act[i]) begin
         if (t[i] + 1 == d && mrd[i]) mrx[i] = sbyte[i];
         t[i]++;
         if (t[i] > d) act[i] = 1'b0;
      end else if (start[i]) begin
         act[i] = 1'b1;
         t[i]   = 1;
         mw[i]  = tx[i];
         mrd[i] = RD_EN && tx[i][23];
      end
   endtask

   always @(negedge clk) begin
      if (cyc > 0) for (int i = 0; i < 2; i++) model_check(i);
      for (int i = 0; i < 2; i++) model_step(i);
   end

   // Slave model (updates SDIO while SCLK is low) plus bus monitors.
   int          rises    [2] = '{0, 0};
   int          done_cnt [2] = '{0, 0};
   int          done_at  [2] = '{0, 0};
   int          csb_rise [2] = '{0, 0};
   logic [23:0] cap      [2] = '{24'h0, 24'h0};
   logic        csb_p    [2] = '{1'b1, 1'b1};
   logic        sclk_p   [2] = '{1'b0, 1'b0};
   int          dq1 [$];

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         if (csb_p[i] === 1'b1 && csb[i] === 1'b0) cap[i] = 24'h0;
         if (csb_p[i] === 1'b0 && csb[i] === 1'b1) csb_rise[i]++;
         if (csb[i] !== 1'b0) rises[i] = 0;
         if (sclk_p[i] === 1'b0 && sclk[i] === 1'b1) begin
            rises[i]++;
            cap[i] = {cap[i][22:0], sdo[i]};
         end
         if (sclk[i] === 1'b0)
            sdio_in[i] = (csb[i] === 1'b0 && rises[i] >= 16 && rises[i] < 24)
                         ? sbyte[i][23 - rises[i]] : 1'b0;
         if (done[i] === 1'b1) begin
            done_cnt[i]++;
            done_at[i] = cyc;
            if (i == 1) dq1.push_back(cyc);
         end
         csb_p[i]  = csb[i];
         sclk_p[i] = sclk[i];
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic kick(input int i, input logic [23:0] w, output int a);
      @(posedge clk); #1;
      start[i] = 1'b1; tx[i] = w; a = cyc;
      @(posedge clk); #1;
      start[i] = 1'b0; tx[i] = ~w;
   endtask

   initial begin
      int a, dc, cr;
      logic [7:0] rexp;
      rexp = RD_EN ? 8'h88 : 8'h00;
      rst_n = 1'b0; start = 2'b00; tx = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_csb", 32'(csb[0]), 32'd1);
      chk("reset_sclk", 32'(sclk[0]), 32'd0);
      chk("reset_sdo", 32'(sdo[0]), 32'd0);
      chk("reset_sdt", 32'(sdt[0]), 32'd1);
      chk("reset_rx", 32'(rx[0]), 32'd0);
      chk("reset_busy_done", 32'({busy[0], done[0]}), 32'd0);
      rst_n = 1'b1;

      // write
      dc = done_cnt[0];
      kick(0, 24'h000818, a);
      wait_cyc(a + 220);
      chk("wr_done_count", 32'(done_cnt[0] - dc), 32'd1);
      chk("wr_done_cycle", 32'(done_at[0] - a), 32'd197);
      chk("wr_sdio_word", 32'(cap[0]), 32'h000818);
      chk("wr_rx_unchanged", 32'(rx[0]), 32'h00);

      // read
      kick(0, 24'h800100, a);
      wait_cyc(a + 130);
      chk("rd_sdt_bit15", 32'(sdt[0]), 32'd0);
      wait_cyc(a + 131);
      chk("rd_sdt_bit16", 32'(sdt[0]), 32'(RD_EN));
      wait_cyc(a + 220);
      chk("rd_done_cycle", 32'(done_at[0] - a), 32'd197);
      chk("rd_rx", 32'(rx[0]), 32'(rexp));
      if (!RD_EN) chk("rd_nomacro_sdio_word", 32'(cap[0]), 32'h800100);

      // start while busy
      dc = done_cnt[0]; cr = csb_rise[0];
      kick(0, 24'h000818, a);
      wait_cyc(a + 59);
      @(posedge clk); #1; start[0] = 1'b1; tx[0] = 24'h8000FF;
      @(posedge clk); #1; start[0] = 1'b0;
      wait_cyc(a + 260);
      chk("busy_start_done_count", 32'(done_cnt[0] - dc), 32'd1);
      chk("busy_start_csb_rises", 32'(csb_rise[0] - cr), 32'd1);
      chk("busy_start_done_cycle", 32'(done_at[0] - a), 32'd197);
      chk("busy_start_rx", 32'(rx[0]), 32'(rexp));

      // reset mid-transfer
      dc = done_cnt[0];
      kick(0, 24'h800100, a);
      wait_cyc(a + 49);
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_csb", 32'(csb[0]), 32'd1);
      chk("rst_mid_sclk", 32'(sclk[0]), 32'd0);
      chk("rst_mid_sdt", 32'(sdt[0]), 32'd1);
      chk("rst_mid_busy", 32'(busy[0]), 32'd0);
      chk("rst_mid_rx", 32'(rx[0]), 32'd0);
      rst_n = 1'b1;
      wait_cyc(a + 260);
      chk("rst_mid_no_done", 32'(done_cnt[0] - dc), 32'd0);
      kick(0, 24'h800100, a);
      wait_cyc(a + 220);
      chk("rst_fresh_done_count", 32'(done_cnt[0] - dc), 32'd1);
      chk("rst_fresh_done_cycle", 32'(done_at[0] - a), 32'd197);
      chk("rst_fresh_rx", 32'(rx[0]), 32'(rexp));

      // back-to-back at minimum divider, start held high
      @(posedge clk); #1;
      start[1] = 1'b1; tx[1] = 24'h80AB00; a = cyc;
      wait_cyc(a + 50);
      chk("b2b_csb_c50", 32'(csb[1]), 32'd0);
      wait_cyc(a + 51);
      chk("b2b_csb_c51", 32'(csb[1]), 32'd1);
      wait_cyc(a + 52);
      chk("b2b_csb_c52", 32'(csb[1]), 32'd1);
      wait_cyc(a + 53);
      chk("b2b_csb_c53", 32'(csb[1]), 32'd0);
      wait_cyc(a + 59);
      @(posedge clk); #1; start[1] = 1'b0;
      wait_cyc(a + 140);
      chk("b2b_done_count", 32'(dq1.size()), 32'd2);
      if (dq1.size() >= 2) begin
         chk("b2b_done1_cycle", 32'(dq1[0] - a), 32'd51);
         chk("b2b_done2_cycle", 32'(dq1[1] - a), 32'd103);
      end
      chk("b2b_rx", 32'(rx[1]), RD_EN ? 32'h5A : 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
